// File: rtl/bw_mult_pkg.sv
// Shared definitions for the Baugh-Wooley multiplier: FSM states and the
// correction constant that folds the sign-bit inversions back into the product.
package bw_mult_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} bw_state_t;

    // 2^w + 2^(2w-1): the accumulator starts here so the inverted rows sum exactly
    function automatic logic [63:0] bw_const(input int w);
        return (64'd1 << w) | (64'd1 << (2 * w - 1));
    endfunction

endpackage

// File: rtl/bw_row_gen.sv
// Builds one Baugh-Wooley partial-product row (unshifted) from the latched
// multiplicand and one multiplier bit, with the sign-position inversions applied.
module bw_row_gen
    import bw_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_q,
    input  logic             b_i,
    input  logic             last_row,
    output logic [WIDTH:0]   row
);

    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] inv_mask;

    assign pp = a_q & {WIDTH{b_i}};

    // Ordinary rows invert only the sign column; the final row inverts everything else
    assign inv_mask = last_row ? {1'b0, {(WIDTH-1){1'b1}}}
                               : {1'b1, {(WIDTH-1){1'b0}}};

    assign row = {1'b0, pp ^ inv_mask};

endmodule

// File: rtl/bw_mult_seq_core.sv
// Iterative signed Baugh-Wooley multiplier: one partial-product row per clock,
// valid/ready operand request in, valid/ready product response out.
module bw_mult_seq_core
    import bw_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]      LAST_ROW = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] BW_C     = (2*WIDTH)'(bw_const(WIDTH));

    bw_state_t            state, next_state;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [CW-1:0]        row_cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       row;
    logic                 last_row;
    logic [2*WIDTH-1:0]   row_shifted;

    assign last_row    = (row_cnt == LAST_ROW);
    assign row_shifted = {{(WIDTH-1){1'b0}}, row} << row_cnt;

    bw_row_gen #(.WIDTH(WIDTH)) u_row_gen (
        .a_q      (a_q),
        .b_i      (b_q[row_cnt]),
        .last_row (last_row),
        .row      (row)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            row_cnt <= '0;
            acc     <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        acc     <= BW_C;
                        row_cnt <= '0;
                    end
                end
                ST_CALC: begin
                    acc     <= acc + row_shifted;
                    row_cnt <= row_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The product is the accumulator itself; it stays put through DONE and after release
    assign out_p = acc;

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = ST_CALC;
            end
            ST_CALC: begin
                busy = 1'b1;
                if (last_row) next_state = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bw_mult_seq_core.sv
// Self-checking bench for bw_mult_seq_core (WIDTH=16) against a plain signed-multiply model.
module tb_bw_mult_seq_core;

    localparam int W = 16;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] out_p;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    bw_mult_seq_core #(.WIDTH(W)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 ACLK = ~ACLK;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint prod;
        prod = longint'($signed(a)) * longint'($signed(b));
        return prod[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Runs one operation; product is captured on the cycle before the release edge
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit noise, output logic [2*W-1:0] p, output int lat);
        int g;
        g = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        tick();
        in_valid = 1'b0;
        if (noise) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (noise) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid  = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (hold) tick();
        p = out_p;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) $display("[TB] FAIL reset_flags got %b need 100", {in_ready, out_valid, busy});
        else n_pass++;
        n_checks++;
        if (out_p !== '0) $display("[TB] FAIL reset_out_p got %h need 00000000", out_p);
        else n_pass++;
        tick();
        ARESET = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [2*W-1:0] p;
        int lat;
        do_op(16'd3, 16'd5, 0, 1'b0, p, lat);
        n_checks++;
        if (p !== 32'h0000000F) $display("[TB] FAIL basic_3x5 got %h need 0000000f", p);
        else n_pass++;
        n_checks++;
        if (lat !== 16) $display("[TB] FAIL basic_latency got %0d need 16", lat);
        else n_pass++;
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) $display("[TB] FAIL basic_release got %b need 010", {out_valid, in_ready, busy});
        else n_pass++;
        n_checks++;
        if (out_p !== 32'h0000000F) $display("[TB] FAIL basic_hold_p got %h need 0000000f", out_p);
        else n_pass++;
    endtask

    task automatic test_edges();
        logic [W-1:0]   ta [5] = '{16'hFFFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000};
        logic [W-1:0]   tb [5] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000};
        logic [2*W-1:0] te [5] = '{32'h00000001, 32'h40000000, 32'hC0008000, 32'h3FFF0001, 32'h00000000};
        logic [2*W-1:0] p;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], 0, 1'b0, p, lat);
            n_checks++;
            if (p !== te[i]) $display("[TB] FAIL edge_%0d %h*%h got %h need %h", i, ta[i], tb[i], p, te[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [2*W-1:0] exp_p;
        int g;
        exp_p = ref_mul(16'h1357, 16'hF00D);
        in_a = 16'h1357;
        in_b = 16'hF00D;
        in_valid = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 100) begin
            tick();
            g++;
        end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'(c % 2);
            in_a = W'($urandom);
            in_b = W'($urandom);
            n_checks++;
            if ({out_valid, in_ready} !== 2'b10 || out_p !== exp_p)
                $display("[TB] FAIL bp_hold_%0d got v/r=%b p=%h need 10 p=%h", c, {out_valid, in_ready}, out_p, exp_p);
            else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (out_valid !== 1'b1 || out_p !== exp_p) $display("[TB] FAIL bp_still_done got v=%b p=%h need 1 p=%h", out_valid, out_p, exp_p);
        else n_pass++;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) $display("[TB] FAIL bp_release got %b need 01", {out_valid, in_ready});
        else n_pass++;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL bp_no_accept busy got %b need 0", busy);
        else n_pass++;
    endtask

    task automatic test_abort();
        logic [2*W-1:0] p;
        int lat;
        in_a = 16'h1234;
        in_b = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL abort_busy_before got %b need 1", busy);
        else n_pass++;
        #2;
        ARESET = 1'b1;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || out_p !== '0)
            $display("[TB] FAIL abort_clear got flags=%b p=%h need 100 p=00000000", {in_ready, out_valid, busy}, out_p);
        else n_pass++;
        tick();
        ARESET = 1'b0;
        tick();
        do_op(16'd2, 16'd3, 0, 1'b0, p, lat);
        n_checks++;
        if (p !== 32'h00000006) $display("[TB] FAIL abort_next_op got %h need 00000006", p);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [W-1:0]   a, b;
        logic [2*W-1:0] p, exp_p;
        int lat;
        for (int k = 0; k < 1000; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            exp_p = ref_mul(a, b);
            repeat ($urandom_range(0, 3)) tick();
            do_op(a, b, $urandom_range(0, 3), 1'b1, p, lat);
            n_checks++;
            if (p !== exp_p) $display("[TB] FAIL rand_%0d %h*%h got %h need %h", k, a, b, p, exp_p);
            else n_pass++;
            n_checks++;
            if (lat !== 16) $display("[TB] FAIL rand_lat_%0d got %0d need 16", k, lat);
            else n_pass++;
        end
    endtask

    initial begin
        ARESET    = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_edges();
        test_backpressure();
        test_abort();
        test_random();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
